// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, width helper and word types for the programmable FIR
// Purpose: default parameter values, accumulator-width function, default-width word typedefs.
// Ports: none.
package fir_pkg;

   localparam int TAPS_DEF   = 4;
   localparam int DATA_W_DEF = 4;
   localparam int COEF_W_DEF = 4;

   // One full product plus enough growth bits to add TAPS of them without overflow,
   // including the case where every operand is the most negative value.
   function automatic int fir_acc_w(input int taps, input int dw, input int cw);
      return dw + cw + $clog2(taps);
   endfunction

   localparam int ACC_W_DEF = fir_acc_w(TAPS_DEF, DATA_W_DEF, COEF_W_DEF);

   typedef logic signed [DATA_W_DEF-1:0]            sample_t;
   typedef logic signed [COEF_W_DEF-1:0]            coef_t;
   typedef logic signed [DATA_W_DEF+COEF_W_DEF-1:0] prod_t;
   typedef logic signed [ACC_W_DEF-1:0]             acc_t;

endpackage

// File: rtl/fir_tap_reg.sv
// rtl/fir_tap_reg.sv - one delay-line stage of the FIR
// Purpose: W-bit register with asynchronous active-low reset, synchronous clear and load enable.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync, wins over en_i), en_i, d_i, q_o.
module fir_tap_reg #(
   parameter int W = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                en_i,
   input  logic signed [W-1:0] d_i,
   output logic signed [W-1:0] q_o
);

   logic signed [W-1:0] q_q;
   logic signed [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clear_i) begin
         q_d = '0;
      end else if (en_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fir_prog.sv
// rtl/fir_prog.sv - pipelined programmable-coefficient direct-form FIR filter
// Purpose: TAPS-deep sample delay line, runtime-writable coefficient bank, registered
//          product stage and registered full-precision adder stage.
// Ports: clk, rst (async, active-low), in_valid/x_in (sample in), clear (sync flush),
//        coef_we/coef_addr/coef_data (coefficient write), out_valid/y_out (result).
module fir_prog
   import fir_pkg::*;
#(
   parameter int TAPS   = TAPS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int COEF_W = COEF_W_DEF
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            in_valid,
   input  logic signed [DATA_W-1:0]                        x_in,
   input  logic                                            clear,
   input  logic                                            coef_we,
   input  logic [$clog2(TAPS)-1:0]                         coef_addr,
   input  logic signed [COEF_W-1:0]                        coef_data,
   output logic                                            out_valid,
   output logic signed [fir_acc_w(TAPS, DATA_W, COEF_W)-1:0] y_out
);

   localparam int ACC_W  = fir_acc_w(TAPS, DATA_W, COEF_W);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int AW     = $clog2(TAPS);

   logic signed [DATA_W-1:0] x_q    [TAPS];
   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [COEF_W-1:0] coef_d [TAPS];
   logic signed [PROD_W-1:0] p_q    [TAPS];
   logic signed [PROD_W-1:0] p_d    [TAPS];
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  y_q;
   logic                     v0_q;
   logic                     v1_q;
   logic                     out_valid_q;

   // Delay line: shifts only on accepted samples, so it never holds bubbles.
   genvar k;
   generate
      for (k = 0; k < TAPS; k++) begin : g_tap
         logic signed [DATA_W-1:0] tap_d;
         if (k == 0) begin : g_head
            assign tap_d = x_in;
         end else begin : g_body
            assign tap_d = x_q[k-1];
         end
         fir_tap_reg #(.W(DATA_W)) u_tap (
            .clk_i  (clk),
            .rst_ni (rst),
            .clear_i(clear),
            .en_i   (in_valid),
            .d_i    (tap_d),
            .q_o    (x_q[k])
         );
      end
   endgenerate

   // Addresses at or above TAPS match no entry, so such writes fall away.
   always_comb begin
      coef_d = coef_q;
      for (int i = 0; i < TAPS; i++) begin
         if (coef_we && coef_addr == AW'(i)) begin
            coef_d[i] = coef_data;
         end
      end
   end

   // Operands are sign-extended to the product width before multiplying.
   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         p_d[i] = PROD_W'(coef_q[i]) * PROD_W'(x_q[i]);
      end
   end

   always_comb begin
      acc_d = '0;
      for (int i = 0; i < TAPS; i++) begin
         acc_d = acc_d + ACC_W'(p_q[i]);
      end
   end

   // Coefficient writes are independent of clear; y_q only moves with a valid result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
            p_q[i]    <= '0;
         end
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         coef_q <= coef_d;
         if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
               p_q[i] <= '0;
            end
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            p_q         <= p_d;
            v0_q        <= in_valid;
            v1_q        <= v0_q;
            out_valid_q <= v1_q;
            if (v1_q) begin
               y_q <= acc_d;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign y_out     = y_q;

endmodule

// File: tb/tb_fir_prog.sv
// tb/tb_fir_prog.sv - self-checking bench for fir_prog
module tb_fir_prog;
   import fir_pkg::*;

   logic              clk;
   logic              rst;
   logic              in_valid;
   sample_t           x_in;
   logic              clear;
   logic              coef_we;
   logic [1:0]        coef_addr;
   coef_t             coef_data;
   logic              out_valid;
   logic signed [9:0] y_out;

   int n_checks = 0;
   int n_fail   = 0;

   fir_prog #(.TAPS(4), .DATA_W(4), .COEF_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .x_in     (x_in),
      .clear    (clear),
      .coef_we  (coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .out_valid(out_valid),
      .y_out    (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Reference: sample history, coefficient values, and results waiting to emerge.
   int m_coef [4];
   int m_hist [4];
   int pipe_v [3];
   int pipe_y [3];
   int m_v;
   int m_y;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_coef[i] = 0;
         m_hist[i] = 0;
      end
      for (int i = 0; i < 3; i++) begin
         pipe_v[i] = 0;
         pipe_y[i] = 0;
      end
      m_v = 0;
      m_y = 0;
   endfunction

   function automatic int dot();
      int s = 0;
      for (int i = 0; i < 4; i++) s += m_coef[i] * m_hist[i];
      return s;
   endfunction

   // A result is fixed by the coefficients in force right after its acceptance edge
   // and becomes visible two edges later.
   function automatic void model_edge(input bit iv, input int x, input bit clr,
                                      input bit we, input int a, input int d);
      if (we) m_coef[a] = d;
      if (clr) begin
         for (int i = 0; i < 4; i++) m_hist[i] = 0;
         for (int i = 0; i < 3; i++) pipe_v[i] = 0;
      end else begin
         if (iv) begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = x;
         end
         pipe_v[2] = pipe_v[1];
         pipe_y[2] = pipe_y[1];
         pipe_v[1] = pipe_v[0];
         pipe_y[1] = pipe_y[0];
         pipe_v[0] = iv;
         pipe_y[0] = dot();
      end
      m_v = pipe_v[2];
      if (m_v != 0) m_y = pipe_y[2];
   endfunction

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic step(input bit iv, input int x, input bit clr,
                       input bit we, input int a, input int d);
      in_valid  = iv;
      x_in      = sample_t'(x);
      clear     = clr;
      coef_we   = we;
      coef_addr = 2'(a);
      coef_data = coef_t'(d);
      @(posedge clk);
      #1;
      model_edge(iv, int'(sample_t'(x)), clr, we, a, int'(coef_t'(d)));
   endtask

   typedef struct {
      bit iv;
      int x;
      bit clr;
      bit we;
      int a;
      int d;
      bit ev;
      int ey;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit iv, input int x, input bit clr, input bit we,
                               input int a, input int d, input bit ev, input int ey);
      vecs.push_back('{iv, x, clr, we, a, d, ev, ey});
   endfunction

   initial begin
      // Impulse through coef {1,2,3,4}
      add(0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 1, 2, 0, 0);
      add(0, 0, 0, 1, 2, 3, 0, 0);
      add(0, 0, 0, 1, 3, 4, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 1, 2);
      add(1, 0, 0, 0, 0, 0, 1, 3);
      add(1, 0, 0, 0, 0, 0, 1, 4);
      add(1, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // Most-negative operands, then mixed signs
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, i, -8, 0, 0);
      for (int i = 0; i < 4; i++) add(1, -8, 0, 0, 0, 0, i >= 2, (i == 2) ? 64 : (i == 3) ? 128 : 0);
      add(0, 0, 0, 0, 0, 0, 1, 192);
      add(0, 0, 0, 0, 0, 0, 1, 256);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, i, 7, 0, 256);
      add(1, -8, 0, 0, 0, 0, 0, 256);
      add(1, -8, 0, 0, 0, 0, 0, 256);
      add(1, -8, 0, 0, 0, 0, 1, -224);
      add(1, -8, 0, 0, 0, 0, 1, -224);
      add(0, 0, 0, 0, 0, 0, 1, -224);
      add(0, 0, 0, 0, 0, 0, 1, -224);
      // Clear with a coefficient write on the same edge, then gapped input
      add(0, 0, 1, 1, 0, 1, 0, -224);
      for (int i = 1; i < 4; i++) add(0, 0, 0, 1, i, 1, 0, -224);
      add(1, 1, 0, 0, 0, 0, 0, -224);
      add(0, 0, 0, 0, 0, 0, 0, -224);
      add(0, 0, 0, 0, 0, 0, 1, 1);
      add(1, 2, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 3, 0, 0, 0, 0, 1, 3);
      add(0, 0, 0, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 0, 1, 6);
      add(0, 0, 0, 0, 0, 0, 0, 6);
      // Coefficient change mid-stream (write on the edge of the sixth sample)
      add(1, 1, 0, 0, 0, 0, 0, 6);
      add(1, 1, 0, 0, 0, 0, 0, 6);
      add(1, 1, 0, 0, 0, 0, 1, 7);
      add(1, 1, 0, 0, 0, 0, 1, 7);
      add(1, 1, 0, 0, 0, 0, 1, 6);
      add(1, 1, 0, 1, 2, 5, 1, 4);
      add(1, 1, 0, 0, 0, 0, 1, 4);
      add(1, 1, 0, 0, 0, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 0, 8);
      // Clear beats a simultaneous sample
      add(0, 0, 0, 1, 1, 2, 0, 8);
      add(0, 0, 0, 1, 2, 3, 0, 8);
      add(0, 0, 0, 1, 3, 4, 0, 8);
      add(1, 7, 1, 0, 0, 0, 0, 8);
      add(1, 2, 0, 0, 0, 0, 0, 8);
      add(0, 0, 0, 0, 0, 0, 0, 8);
      add(0, 0, 0, 0, 0, 0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 0, 2);

      model_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      x_in      = '0;
      clear     = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", int'(out_valid), 0);
      check("reset y_out", int'(y_out), 0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].iv, vecs[i].x, vecs[i].clr, vecs[i].we, vecs[i].a, vecs[i].d);
         check($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].ev));
         check($sformatf("vec%0d y_out", i), int'(y_out), vecs[i].ey);
      end

      for (int i = 0; i < 400; i++) begin
         bit iv;
         bit clr;
         bit we;
         iv  = ($urandom_range(0, 99) < 70);
         clr = ($urandom_range(0, 39) == 0);
         we  = ($urandom_range(0, 7) == 0);
         step(iv, int'($urandom_range(0, 15)), clr, we,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
         check($sformatf("rnd%0d out_valid", i), int'(out_valid), m_v);
         check($sformatf("rnd%0d y_out", i), int'(y_out), m_y);
      end

      // Asynchronous reset between edges with samples in flight
      step(0, 0, 1, 1, 0, 1);
      for (int i = 1; i < 4; i++) step(0, 0, 0, 1, i, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 3, 0, 0, 0, 0);
         check($sformatf("pre-reset%0d y_out", i), int'(y_out), m_y);
      end
      check("pre-reset nonzero", int'(y_out != 0), 1);
      #2;
      rst = 1'b0;
      #1;
      check("async reset out_valid", int'(out_valid), 0);
      check("async reset y_out", int'(y_out), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 0);
         check($sformatf("post-reset%0d out_valid", i), int'(out_valid), 0);
      end
      for (int i = 0; i < 6; i++) begin
         step(i < 4, 5, 0, 0, 0, 0);
         check($sformatf("zero-coef%0d out_valid", i), int'(out_valid), m_v);
         check($sformatf("zero-coef%0d y_out", i), int'(y_out), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
